ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX->MEM pipeline register directly downstream of the ALU.
//  Captures the ALU result, flags and the instruction's side-band control (rd, write/memory enables, store data).
//  Resolves beq/bne from the ALU zero flag and presents one registered beat to the memory stage.
//  The beat moves on a valid/ready handshake, with stall and flush support.
// PARAMETERS
//  WORD_LENGTH  32  datapath width; applies to the ALU result and store data
//  RD_WIDTH     5   width of the destination register index
// PORTS
//  clk            in   1            rising-edge clock
//  reset          in   1            asynchronous, active-low reset
//  flush          in   1            synchronous kill of every beat held in the stage
//  in_valid       in   1            EX beat present
//  in_ready       out  1            stage can accept the EX beat
//  alu_result     in   WORD_LENGTH  ALU dataC
//  alu_zero       in   1            ALU zero flag
//  alu_carry      in   1            ALU carry flag
//  alu_negative   in   1            ALU negative flag
//  in_rd          in   RD_WIDTH     destination register
//  in_reg_write   in   1            register write enable
//  in_mem_read    in   1            load
//  in_mem_write   in   1            store
//  in_store_data  in   WORD_LENGTH  rt value for stores
//  in_branch      in   1            conditional branch instruction
//  in_bne         in   1            1 = bne, 0 = beq; ignored when in_branch=0
//  out_valid      out  1            MEM beat present
//  out_ready      in   1            MEM stage accepts the beat
//  out_result     out  WORD_LENGTH  registered ALU result
//  out_flags      out  3            {negative, carry, zero}
//  out_rd         out  RD_WIDTH     registered rd
//  out_reg_write  out  1            gated register write enable
//  out_mem_read   out  1            gated load enable
//  out_mem_write  out  1            gated store enable
//  out_store_data out  WORD_LENGTH  registered store data
//  branch_taken   out  1            registered branch decision
// BEHAVIOUR
//  - Reset: every output is 0 (out_valid=0, all data and flags 0). The skid entry is emptied. in_ready=1 after reset.
//  - Accept: a beat is accepted when in_valid & in_ready at the clk edge.
//  - Latency: 1 cycle from acceptance to out_valid.
//  - Drain: a beat leaves on out_valid & out_ready.
//  - Without the skid buffer, in_ready = ~out_valid | out_ready, combinationally.
//  - Simultaneous drain and accept: the new beat replaces the old one in the same edge with no bubble, giving full throughput.
//  - Stall: while out_valid & ~out_ready, every output holds stable.
//  - Branch: branch_taken = in_branch & (alu_zero ^ in_bne), captured with the beat.
//  - $zero: out_reg_write is forced 0 when in_rd == 0.
//  - Gating: out_reg_write, out_mem_read, out_mem_write and branch_taken read 0 whenever out_valid=0.
//  - Flush (sync, highest priority): out_valid becomes 0, the gated controls become 0, and the skid entry is cleared.
//    A beat offered in the flush cycle is discarded even if in_ready=1. Data registers may keep stale values.
//  - Reset mid-stall: the held beat is lost and all outputs go to 0 asynchronously.
//  - No arithmetic is done here: the ALU result and flags pass through unmodified.
// CONFIGURATION
//  EX_MEM_SKID_EN defined: a 1-entry skid buffer is added.
//   - in_ready = ~skid_full, registered, so there is no combinational path from out_ready to in_ready.
//   - A beat accepted while the output is stalled goes into the skid entry.
//   - On drain, the skid entry moves to the output in the same edge and in_ready returns to 1 the next cycle.
//   - Output order is strictly FIFO.
//  EX_MEM_SKID_EN undefined: single register stage with combinational in_ready as above; no skid storage.
// TESTING
//  - Reset: assert reset=0 mid-beat -> all outputs are 0 immediately; after release in_ready=1.
//  - Passthrough: alu_result=32'h0000_0007, in_rd=5, in_reg_write=1, out_ready=1 -> next cycle out_valid=1, out_result=7, out_rd=5, out_reg_write=1.
//  - Branch and $zero: beq with alu_zero=1 -> branch_taken=1; bne with alu_zero=1 -> branch_taken=0; in_rd=0 with in_reg_write=1 -> out_reg_write=0.
//  - Stall without skid: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs hold; raising out_ready -> back-to-back beats with no bubble.
//  - Stall with EX_MEM_SKID_EN: feed beats A,B,C with out_ready=0 -> A is on the output, B is in skid, in_ready=0; release -> output order A, B, C.
//  - Flush: flush=1 with out_valid=1 and a beat offered -> next cycle out_valid=0, out_mem_write=0; the offered beat never appears.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with valid/ready handshake, stall, flush and beq/bne resolution.
// Define EX_MEM_SKID_EN to add a 1-entry skid buffer that registers in_ready.
module ex_mem_stage #(
    parameter int WORD_LENGTH = 32,
    parameter int RD_WIDTH    = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_LENGTH-1:0] alu_result,
    input  logic                   alu_zero,
    input  logic                   alu_carry,
    input  logic                   alu_negative,
    input  logic [RD_WIDTH-1:0]    in_rd,
    input  logic                   in_reg_write,
    input  logic                   in_mem_read,
    input  logic                   in_mem_write,
    input  logic [WORD_LENGTH-1:0] in_store_data,
    input  logic                   in_branch,
    input  logic                   in_bne,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORD_LENGTH-1:0] out_result,
    output logic [2:0]             out_flags,
    output logic [RD_WIDTH-1:0]    out_rd,
    output logic                   out_reg_write,
    output logic                   out_mem_read,
    output logic                   out_mem_write,
    output logic [WORD_LENGTH-1:0] out_store_data,
    output logic                   branch_taken
);

    typedef struct packed {
        logic [WORD_LENGTH-1:0] result;
        logic [2:0]             flags;
        logic [RD_WIDTH-1:0]    rd;
        logic                   reg_write;
        logic                   mem_read;
        logic                   mem_write;
        logic [WORD_LENGTH-1:0] store_data;
        logic                   branch;
    } beat_t;

    beat_t in_beat;
    beat_t out_q;
    logic  valid_q;
    logic  out_space;

    // Branch decision and $zero suppression are resolved before capture.
    always_comb begin
        in_beat            = '0;
        in_beat.result     = alu_result;
        in_beat.flags      = {alu_negative, alu_carry, alu_zero};
        in_beat.rd         = in_rd;
        in_beat.reg_write  = in_reg_write & (in_rd != '0);
        in_beat.mem_read   = in_mem_read;
        in_beat.mem_write  = in_mem_write;
        in_beat.store_data = in_store_data;
        in_beat.branch     = in_branch & (alu_zero ^ in_bne);
    end

    assign out_space = ~valid_q | out_ready;

`ifdef EX_MEM_SKID_EN
    beat_t skid_q;
    logic  skid_full;

    assign in_ready = ~skid_full;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q   <= 1'b0;
            out_q     <= '0;
            skid_q    <= '0;
            skid_full <= 1'b0;
        end else if (flush) begin
            valid_q         <= 1'b0;
            out_q.reg_write <= 1'b0;
            out_q.mem_read  <= 1'b0;
            out_q.mem_write <= 1'b0;
            out_q.branch    <= 1'b0;
            skid_full       <= 1'b0;
        end else if (out_space) begin
            // A full skid has priority; in_ready was low so no new beat can arrive.
            if (skid_full) begin
                out_q     <= skid_q;
                valid_q   <= 1'b1;
                skid_full <= 1'b0;
            end else begin
                valid_q <= in_valid;
                if (in_valid) begin
                    out_q <= in_beat;
                end
            end
        end else if (in_valid && !skid_full) begin
            skid_q    <= in_beat;
            skid_full <= 1'b1;
        end
    end
`else
    assign in_ready = out_space;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            out_q   <= '0;
        end else if (flush) begin
            valid_q         <= 1'b0;
            out_q.reg_write <= 1'b0;
            out_q.mem_read  <= 1'b0;
            out_q.mem_write <= 1'b0;
            out_q.branch    <= 1'b0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                out_q <= in_beat;
            end
        end
    end
`endif

    assign out_valid      = valid_q;
    assign out_result     = out_q.result;
    assign out_flags      = out_q.flags;
    assign out_rd         = out_q.rd;
    assign out_store_data = out_q.store_data;
    assign out_reg_write  = valid_q & out_q.reg_write;
    assign out_mem_read   = valid_q & out_q.mem_read;
    assign out_mem_write  = valid_q & out_q.mem_write;
    assign branch_taken   = valid_q & out_q.branch;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomized + directed bench for ex_mem_stage against a FIFO-of-beats reference model.
// Honours EX_MEM_SKID_EN the same way as the design (stage capacity 2 instead of 1).
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_negative;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [31:0] in_store_data;
    logic        in_branch;
    logic        in_bne;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic [31:0] out_store_data;
    logic        branch_taken;

    ex_mem_stage #(.WORD_LENGTH(32), .RD_WIDTH(5)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_negative(alu_negative), .in_rd(in_rd), .in_reg_write(in_reg_write),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .in_store_data(in_store_data), .in_branch(in_branch), .in_bne(in_bne),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .out_rd(out_rd), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_store_data(out_store_data), .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [2:0]  flags;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic [31:0] sd;
        logic        bt;
    } exp_beat_t;

    exp_beat_t model_q[$];
    int checks = 0;
    int errors = 0;
    logic last_fire;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_in_ready();
`ifdef EX_MEM_SKID_EN
        return model_q.size() < 2;
`else
        return (model_q.size() == 0) || out_ready;
`endif
    endfunction

    task automatic set_beat(input logic [31:0] res, input logic [2:0] nzc, input logic [4:0] rd,
                            input logic rw, input logic mr, input logic mw,
                            input logic [31:0] sd, input logic br, input logic bne);
        alu_result    = res;
        alu_negative  = nzc[2];
        alu_carry     = nzc[1];
        alu_zero      = nzc[0];
        in_rd         = rd;
        in_reg_write  = rw;
        in_mem_read   = mr;
        in_mem_write  = mw;
        in_store_data = sd;
        in_branch     = br;
        in_bne        = bne;
    endtask

    task automatic check_outputs();
        if (model_q.size() > 0) begin
            check("out_valid", out_valid, 1);
            check("out_result", out_result, model_q[0].result);
            check("out_flags", out_flags, model_q[0].flags);
            check("out_rd", out_rd, model_q[0].rd);
            check("out_reg_write", out_reg_write, model_q[0].rw);
            check("out_mem_read", out_mem_read, model_q[0].mr);
            check("out_mem_write", out_mem_write, model_q[0].mw);
            check("out_store_data", out_store_data, model_q[0].sd);
            check("branch_taken", branch_taken, model_q[0].bt);
        end else begin
            check("out_valid", out_valid, 0);
            check("idle_reg_write", out_reg_write, 0);
            check("idle_mem_read", out_mem_read, 0);
            check("idle_mem_write", out_mem_write, 0);
            check("idle_branch", branch_taken, 0);
        end
    endtask

    // Called at a negedge with beat fields already set; returns at the next negedge.
    task automatic cycle(input logic v, input logic ordy, input logic fl);
        exp_beat_t e;
        logic rdy;
        in_valid  = v;
        out_ready = ordy;
        flush     = fl;
        #1;
        check_outputs();
        rdy = exp_in_ready();
        check("in_ready", in_ready, rdy);
        e.result = alu_result;
        e.flags  = {alu_negative, alu_carry, alu_zero};
        e.rd     = in_rd;
        e.rw     = in_reg_write && (in_rd != 0);
        e.mr     = in_mem_read;
        e.mw     = in_mem_write;
        e.sd     = in_store_data;
        e.bt     = in_branch && (alu_zero != in_bne);
        last_fire = v && rdy && !fl;
        if (fl) begin
            model_q.delete();
        end else begin
            if (model_q.size() > 0 && ordy) void'(model_q.pop_front());
            if (v && rdy) model_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all_zero();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_flags", out_flags, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_store_data", out_store_data, 0);
        check("rst_out_ctrl", {out_reg_write, out_mem_read, out_mem_write, branch_taken}, 0);
    endtask

    initial begin
        int idx;
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        set_beat(32'h0, 3'b000, 5'd0, 0, 0, 0, 32'h0, 0, 0);
        repeat (2) @(negedge clk);
        #1;
        check_all_zero();
        reset = 1'b1;
        #1;
        check("post_reset_in_ready", in_ready, 1);
        @(negedge clk);

        // Passthrough
        set_beat(32'h0000_0007, 3'b000, 5'd5, 1, 0, 0, 32'h0, 0, 0);
        cycle(1, 1, 0);
        set_beat(32'h0, 3'b000, 5'd0, 0, 0, 0, 32'h0, 0, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);

        // beq taken, bne not taken, write to $zero suppressed
        set_beat(32'h0, 3'b001, 5'd3, 0, 0, 0, 32'h0, 1, 0);
        cycle(1, 1, 0);
        set_beat(32'h0, 3'b001, 5'd4, 0, 0, 0, 32'h0, 1, 1);
        cycle(1, 1, 0);
        set_beat(32'h1234_5678, 3'b110, 5'd0, 1, 1, 0, 32'hdead_beef, 0, 0);
        cycle(1, 1, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);

        // Stall with three beats offered; each held until accepted
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (idx < 3) begin
                set_beat(32'hA000_0000 + idx, 3'(idx), 5'(idx + 1), 1, 0, 1, 32'h5000_0000 + idx, 0, 0);
                cycle(1, c >= 3, 0);
                if (last_fire) idx++;
            end else begin
                cycle(0, 1, 0);
            end
        end
        check("stall_all_accepted", idx, 3);

        // Flush with a valid output and a beat offered
        set_beat(32'h0000_0011, 3'b000, 5'd7, 1, 0, 1, 32'h1, 0, 0);
        cycle(1, 0, 0);
        set_beat(32'h0000_0022, 3'b000, 5'd8, 1, 0, 1, 32'h2, 0, 0);
        cycle(1, 0, 1);
        check("flush_mem_write", out_mem_write, 0);
        cycle(0, 1, 0);
        cycle(0, 1, 0);

        // Reset in the middle of a stall
        set_beat(32'h0000_0033, 3'b111, 5'd9, 1, 1, 0, 32'h3, 1, 0);
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero();
        model_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_release_in_ready", in_ready, 1);
        @(negedge clk);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            set_beat($urandom, 3'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
            cycle($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0);
        end
        for (int c = 0; c < 4; c++) cycle(0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
